// File: rtl/clarvi_alu_sequencer.sv
// Sequences one 64-bit operation through the byte-serial 8-bit ALU, one slice per cycle,
// in the part order the op needs, and reassembles the full-width result.
module clarvi_alu_sequencer #(
  parameter int XLEN   = 64,
  parameter int SLICE  = 8,
  parameter int CTRL_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CTRL_W-1:0] req_ctrl,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [XLEN-1:0]   req_rs2,
  input  logic              req_reverse,
  input  logic              req_is32,
  input  logic              hold,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [2:0]        alu_part,
  output logic [SLICE-1:0]  alu_rs1_byte,
  output logic [SLICE-1:0]  alu_rs2_byte,
  output logic              alu_stall,
  input  logic [SLICE-1:0]  alu_result,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_result
);

  localparam int NPARTS = XLEN / SLICE;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [XLEN-1:0]     rs1_q, rs1_d, rs2_q, rs2_d, result_q, result_d;
  logic                reverse_q, reverse_d, is32_q, is32_d;
  logic [2:0]          step_q, step_d;
  logic [2:0]          cur_part;
  logic                accept;

  // reverse W ops walk the low word MSB-first, then the high word MSB-first
  always_comb begin
    if (!reverse_q)  cur_part = step_q;
    else if (is32_q) cur_part = {step_q[2], ~step_q[1:0]};
    else             cur_part = ~step_q;
  end

  assign req_ready = (state_q == IDLE) || ((state_q == DONE) && resp_ready);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      reverse_q <= 1'b0;
      is32_q    <= 1'b0;
      result_q  <= '0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      reverse_q <= reverse_d;
      is32_q    <= is32_d;
      result_q  <= result_d;
      step_q    <= step_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    reverse_d = reverse_q;
    is32_d    = is32_q;
    result_d  = result_q;
    step_d    = step_q;
    case (state_q)
      RUN: begin
        if (!hold) begin
          for (int i = 0; i < NPARTS; i++)
            if (cur_part == 3'(i)) result_d[i*SLICE +: SLICE] = alu_result;
          step_d = step_q + 3'd1;
          if (step_q == 3'd7) state_d = DONE;
        end
      end
      DONE:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d   = RUN;
      ctrl_d    = req_ctrl;
      rs1_d     = req_rs1;
      rs2_d     = req_rs2;
      reverse_d = req_reverse;
      is32_d    = req_is32;
      result_d  = '0;
      step_d    = '0;
    end
  end

  always_comb begin
    alu_ctrl     = ctrl_q;
    alu_part     = 3'd0;
    alu_rs1_byte = '0;
    alu_rs2_byte = '0;
    alu_stall    = 1'b1;
    resp_valid   = (state_q == DONE);
    resp_result  = result_q;
    if (state_q == RUN) begin
      alu_part  = cur_part;
      alu_stall = hold;
      for (int i = 0; i < NPARTS; i++)
        if (cur_part == 3'(i)) begin
          alu_rs1_byte = rs1_q[i*SLICE +: SLICE];
          alu_rs2_byte = rs2_q[i*SLICE +: SLICE];
        end
    end
  end

endmodule

// File: tb/tb_clarvi_alu_sequencer.sv
// Directed bench for clarvi_alu_sequencer with a tiny ALU model: ctrl[0]=0 add with carry, 1 pass rs1.
module tb_clarvi_alu_sequencer;
  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_ctrl;
  logic [63:0] req_rs1, req_rs2;
  logic        req_reverse, req_is32, hold;
  logic [31:0] alu_ctrl;
  logic [2:0]  alu_part;
  logic [7:0]  alu_rs1_byte, alu_rs2_byte, alu_result;
  logic        alu_stall, resp_valid, resp_ready;
  logic [63:0] resp_result;

  int total = 0;
  int bad   = 0;

  clarvi_alu_sequencer dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_reverse(req_reverse), .req_is32(req_is32),
    .hold(hold), .alu_ctrl(alu_ctrl), .alu_part(alu_part),
    .alu_rs1_byte(alu_rs1_byte), .alu_rs2_byte(alu_rs2_byte), .alu_stall(alu_stall),
    .alu_result(alu_result), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result)
  );

  always #5 clock = ~clock;

  // ALU model: carry state only advances when not stalled
  logic       carry_q = 1'b0;
  logic [8:0] sum;
  always_comb begin
    sum = {1'b0, alu_rs1_byte} + {1'b0, alu_rs2_byte} + {8'd0, (alu_part == 3'd0) ? 1'b0 : carry_q};
    alu_result = alu_ctrl[0] ? alu_rs1_byte : sum[7:0];
  end
  always @(posedge clock) if (!alu_stall) carry_q <= sum[8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] c, input logic [63:0] a, input logic [63:0] b,
                           input logic rev, input logic w);
    req_valid = 1'b1; req_ctrl = c; req_rs1 = a; req_rs2 = b; req_reverse = rev; req_is32 = w;
  endtask

  logic [2:0]  exp_part [8];
  logic [63:0] saved;

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_ctrl = '0; req_rs1 = '0; req_rs2 = '0;
    req_reverse = 1'b0; req_is32 = 1'b0; hold = 1'b0; resp_ready = 1'b0;
    tick(); tick();
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_result", resp_result, 64'd0);
    check("rst_alu_stall", 64'(alu_stall), 64'd1);
    check("rst_alu_part", 64'(alu_part), 64'd0);
    check("rst_bytes", {48'd0, alu_rs1_byte, alu_rs2_byte}, 64'd0);
    reset = 1'b1;
    tick();

    // forward add: 0xFF + 0x01
    drive_req(32'h0, 64'hFF, 64'h01, 1'b0, 1'b0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fwd_part%0d", i), 64'(alu_part), 64'(i));
      check($sformatf("fwd_stall%0d", i), 64'(alu_stall), 64'd0);
      check($sformatf("fwd_rdy%0d", i), 64'(req_ready), 64'd0);
      tick();
    end
    check("fwd_resp_valid", 64'(resp_valid), 64'd1);
    check("fwd_result", resp_result, 64'h100);
    check("fwd_done_stall", 64'(alu_stall), 64'd1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("fwd_idle_valid", 64'(resp_valid), 64'd0);
    check("fwd_idle_ready", 64'(req_ready), 64'd1);

    // reverse 64-bit pass-through
    drive_req(32'h1, 64'h0102030405060708, 64'h0, 1'b1, 1'b0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rev_part%0d", i), 64'(alu_part), 64'(7 - i));
      check($sformatf("rev_byte%0d", i), 64'(alu_rs1_byte), 64'(i + 1));
      tick();
    end
    check("rev_result", resp_result, 64'h0102030405060708);

    // backpressure with a pending request that must not be taken
    drive_req(32'hCAFE0001, 64'h1122334455667788, 64'h0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid%0d", i), 64'(resp_valid), 64'd1);
      check($sformatf("bp_result%0d", i), resp_result, 64'h0102030405060708);
      check($sformatf("bp_ready%0d", i), 64'(req_ready), 64'd0);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    check("bp_same_edge_ready", 64'(req_ready), 64'd1);
    tick();
    resp_ready = 1'b0;
    req_valid = 1'b0;

    // reverse W order, accepted straight out of DONE
    exp_part = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4};
    check("w_resp_valid_low", 64'(resp_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("w_part%0d", i), 64'(alu_part), 64'(exp_part[i]));
      check($sformatf("w_ctrl%0d", i), 64'(alu_ctrl), 64'h0000_0000_CAFE_0001);
      tick();
    end
    check("w_result", resp_result, 64'h1122334455667788);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // hold three cycles at step 4; carry must survive the hold
    drive_req(32'h0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    hold = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("hold_part%0d", i), 64'(alu_part), 64'd4);
      check($sformatf("hold_stall%0d", i), 64'(alu_stall), 64'd1);
      check($sformatf("hold_partial%0d", i), resp_result, 64'd0);
      tick();
    end
    hold = 1'b0;
    #1;
    check("hold_release_stall", 64'(alu_stall), 64'd0);
    check("hold_release_part", 64'(alu_part), 64'd4);
    for (int i = 0; i < 3; i++) tick();
    check("hold_not_yet_valid", 64'(resp_valid), 64'd0);
    tick();
    check("hold_resp_valid", 64'(resp_valid), 64'd1);
    check("hold_result", resp_result, 64'h1_0000_0000);
    saved = resp_result;
    hold = 1'b1;
    tick();
    hold = 1'b0;
    check("hold_ignored_done", resp_result, saved);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // reset in the middle of an op
    drive_req(32'h1, 64'hDEAD_BEEF_0BAD_F00D, 64'h0, 1'b0, 1'b0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mid_part5", 64'(alu_part), 64'd5);
    reset = 1'b0;
    tick();
    check("mid_rst_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd1);
    check("mid_rst_stall", 64'(alu_stall), 64'd1);
    check("mid_rst_result", resp_result, 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("mid_no_resp", 64'(resp_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
